// File: rtl/kv_vector_sram_pkg.sv
// Package: kv_vector_sram_pkg
// Shared definitions for the K/V vector store. These are the vector types,
// the sequence length and the controller-facing state encoding.
//   MAX_SEQ_LEN      : number of sequence positions (default DEPTH / NUM_PASSES)
//   K_VECTOR_T       : one K vector
//   V_VECTOR_T       : one V vector
//   kv_sram_state_e  : S_FILL / S_STREAM / S_DONE
package kv_vector_sram_pkg;

  localparam int unsigned MAX_SEQ_LEN = 4;

  typedef logic [15:0] K_VECTOR_T;
  typedef logic [15:0] V_VECTOR_T;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } kv_sram_state_e;

endpackage

// File: rtl/kv_vector_sram_if.sv
// Interface: kv_vector_sram_if
// Groups the two handshakes of the vector store.
//   write side : ctrl_vld, wr_vector (controller -> store), sram_rdy (store -> controller)
//   read side  : rd_vld, rd_vector, rd_last, rd_pass_last (store -> datapath),
//                rd_rdy (datapath -> store)
// Modports:
//   slave  : the vector store itself
//   master : the controller / attention datapath side
interface kv_vector_sram_if
  import kv_vector_sram_pkg::*;
#(
  parameter int unsigned VEC_BITS = $bits(K_VECTOR_T)
);

  logic                ctrl_vld;
  logic [VEC_BITS-1:0] wr_vector;
  logic                sram_rdy;
  logic                rd_vld;
  logic                rd_rdy;
  logic [VEC_BITS-1:0] rd_vector;
  logic                rd_last;
  logic                rd_pass_last;

  modport slave (
    input  ctrl_vld,
    input  wr_vector,
    output sram_rdy,
    output rd_vld,
    input  rd_rdy,
    output rd_vector,
    output rd_last,
    output rd_pass_last
  );

  modport master (
    output ctrl_vld,
    output wr_vector,
    input  sram_rdy,
    input  rd_vld,
    output rd_rdy,
    input  rd_vector,
    input  rd_last,
    input  rd_pass_last
  );

endinterface

// File: rtl/kv_vector_sram_array.sv
// Module: vec_sram_array
// DEPTH x WIDTH flop-based storage, one synchronous write port and one
// combinational read port. Contents are never reset. Kept behind this
// boundary so an SRAM macro can replace it.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module vec_sram_array #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/kv_vector_sram.sv
// Module: kv_vector_sram
// Stores one full sequence of K (or V) vectors written by the memory
// controller, then replays the whole sequence NUM_PASSES times (one pass per
// Q vector) to the attention datapath through a registered output stage.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus        : kv_vector_sram_if.slave (write and read handshakes)
//   start      : in S_DONE, rearm for a new load
//   done       : all passes delivered
//   parity_err : sticky parity error (only with KV_SRAM_PARITY_EN)
// Build option: define KV_SRAM_PARITY_EN to store and check an even-parity
// bit per entry.
module kv_vector_sram
  import kv_vector_sram_pkg::*;
#(
  parameter int unsigned DEPTH      = MAX_SEQ_LEN,
  parameter int unsigned NUM_PASSES = MAX_SEQ_LEN,
  parameter int unsigned VEC_BITS   = $bits(K_VECTOR_T)
) (
  input  logic                   clk,
  input  logic                   rst,
  kv_vector_sram_if.slave        bus,
  input  logic                   start,
`ifdef KV_SRAM_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   done
);

  // DEPTH=1 still needs a 1-bit pointer; it simply stays at 0.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_PASSES) + 1;
`ifdef KV_SRAM_PARITY_EN
  localparam int unsigned MEM_W = VEC_BITS + 1;
`else
  localparam int unsigned MEM_W = VEC_BITS;
`endif

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0] PASS_NUM  = CNT_W'(NUM_PASSES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  kv_sram_state_e      state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_last_q, rd_last_d;
  logic                rd_pass_last_q, rd_pass_last_d;
  logic [VEC_BITS-1:0] rd_vector_q, rd_vector_d;
`ifdef KV_SRAM_PARITY_EN
  logic                parity_err_q, parity_err_d;
`endif

  logic             sram_rdy;
  logic             wr_fire;
  logic             rd_hs;
  logic             rd_load;
  logic [MEM_W-1:0] mem_wdata;
  logic [MEM_W-1:0] mem_rdata;

  // ---------------------------------------------------------------- storage
`ifdef KV_SRAM_PARITY_EN
  // Stored parity bit makes the XOR over the whole entry zero.
  assign mem_wdata = {^bus.wr_vector, bus.wr_vector};
`else
  assign mem_wdata = bus.wr_vector;
`endif

  vec_sram_array #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W),
    .AW    (PTR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // ----------------------------------------------------------- event terms
  assign wr_fire = bus.ctrl_vld && sram_rdy;
  assign rd_hs   = rd_vld_q && bus.rd_rdy;
  // Output register refills when empty or being drained, while passes remain.
  assign rd_load = (state_q == S_STREAM) && (!rd_vld_q || bus.rd_rdy) &&
                   (pass_cnt_q < PASS_NUM);

  // -------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pass_cnt_q     <= '0;
      rd_vld_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_pass_last_q <= 1'b0;
      rd_vector_q    <= '0;
`ifdef KV_SRAM_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pass_cnt_q     <= pass_cnt_d;
      rd_vld_q       <= rd_vld_d;
      rd_last_q      <= rd_last_d;
      rd_pass_last_q <= rd_pass_last_d;
      rd_vector_q    <= rd_vector_d;
`ifdef KV_SRAM_PARITY_EN
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  // ------------------------------------------------------- next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL:   if (wr_fire && (wr_ptr_q == PTR_LAST)) state_d = S_STREAM;
      S_STREAM: if (rd_hs && rd_last_q && rd_pass_last_q) state_d = S_DONE;
      S_DONE:   if (start) state_d = S_FILL;
      default:  state_d = S_FILL;
    endcase
  end

  // -------------------------------------------------------- datapath logic
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    pass_cnt_d     = pass_cnt_q;
    rd_vld_d       = rd_vld_q;
    rd_last_d      = rd_last_q;
    rd_pass_last_d = rd_pass_last_q;
    rd_vector_d    = rd_vector_q;
`ifdef KV_SRAM_PARITY_EN
    parity_err_d   = parity_err_q;
`endif

    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end

    if (rd_load) begin
      rd_vld_d       = 1'b1;
      rd_vector_d    = mem_rdata[VEC_BITS-1:0];
      rd_last_d      = (rd_ptr_q == PTR_LAST);
      rd_pass_last_d = (pass_cnt_q == PASS_LAST);
      if (rd_ptr_q == PTR_LAST) begin
        rd_ptr_d   = '0;
        pass_cnt_d = pass_cnt_q + CNT_ONE;
      end else begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end
`ifdef KV_SRAM_PARITY_EN
      if (^mem_rdata) parity_err_d = 1'b1;
`endif
    end else if (rd_hs) begin
      rd_vld_d = 1'b0;
    end

    if ((state_q == S_DONE) && start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      pass_cnt_d   = '0;
`ifdef KV_SRAM_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------- output logic
  always_comb begin
    // Held low while rst is asserted so no write can be offered during reset.
    sram_rdy         = (state_q == S_FILL) && !rst;
    done             = (state_q == S_DONE);
    bus.sram_rdy     = sram_rdy;
    bus.rd_vld       = rd_vld_q;
    bus.rd_vector    = rd_vector_q;
    bus.rd_last      = rd_last_q;
    bus.rd_pass_last = rd_pass_last_q;
`ifdef KV_SRAM_PARITY_EN
    parity_err       = parity_err_q;
`endif
  end

endmodule

// File: tb/tb_kv_vector_sram.sv
// Testbench: tb_kv_vector_sram
// Directed checks of kv_vector_sram: instance A (DEPTH=4, NUM_PASSES=2) and
// instance B (DEPTH=1, NUM_PASSES=1). KV_SRAM_PARITY_EN adds the parity_err port.
module tb_kv_vector_sram;

  logic clk = 1'b0;
  logic rst;
  logic start_a, done_a;
  logic start_b, done_b;
`ifdef KV_SRAM_PARITY_EN
  logic parity_err_a, parity_err_b;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  kv_vector_sram_if #(.VEC_BITS(8)) bus_a ();
  kv_vector_sram_if #(.VEC_BITS(8)) bus_b ();

  kv_vector_sram #(
    .DEPTH      (4),
    .NUM_PASSES (2),
    .VEC_BITS   (8)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_a.slave),
    .start      (start_a),
`ifdef KV_SRAM_PARITY_EN
    .parity_err (parity_err_a),
`endif
    .done       (done_a)
  );

  kv_vector_sram #(
    .DEPTH      (1),
    .NUM_PASSES (1),
    .VEC_BITS   (8)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_b.slave),
    .start      (start_b),
`ifdef KV_SRAM_PARITY_EN
    .parity_err (parity_err_b),
`endif
    .done       (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write four vectors base..base+3 with ctrl_vld held, then check the
  // two-cycle latency to the first rd_vld. Leaves rd_vld=1 with entry 0.
  task automatic fill_a(input logic [7:0] base);
    bus_a.ctrl_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.wr_vector = base + 8'(i);
      check("fill_rdy", 32'(bus_a.sram_rdy), 32'd1);
      tick();
    end
    check("fill_closed", 32'(bus_a.sram_rdy), 32'd0);
    check("fill_lat1_vld", 32'(bus_a.rd_vld), 32'd0);
    bus_a.wr_vector = 8'hEE;
    tick();
    check("fill_lat2_vld", 32'(bus_a.rd_vld), 32'd1);
    check("fill_first_vec", 32'(bus_a.rd_vector), 32'(base));
    check("fill_no_accept", 32'(bus_a.sram_rdy), 32'd0);
    bus_a.ctrl_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bp_pat;
    int unsigned idx;
    int unsigned cyc;

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.ctrl_vld = 1'b0; bus_a.wr_vector = '0; bus_a.rd_rdy = 1'b0;
    bus_b.ctrl_vld = 1'b0; bus_b.wr_vector = '0; bus_b.rd_rdy = 1'b0;
    bp_pat = 4'b1001;

    // Reset state
    tick();
    tick();
    check("rst_sram_rdy", 32'(bus_a.sram_rdy), 32'd0);
    check("rst_rd_vld", 32'(bus_a.rd_vld), 32'd0);
    check("rst_rd_vector", 32'(bus_a.rd_vector), 32'd0);
    check("rst_rd_last", 32'(bus_a.rd_last), 32'd0);
    check("rst_pass_last", 32'(bus_a.rd_pass_last), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_sram_rdy", 32'(bus_a.sram_rdy), 32'd1);

    // Fill A0..A3, then stream both passes with rd_rdy held
    fill_a(8'hA0);
    bus_a.rd_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("str_vld", 32'(bus_a.rd_vld), 32'd1);
      check("str_vec", 32'(bus_a.rd_vector), 32'(8'hA0 + 8'(k % 4)));
      check("str_last", 32'(bus_a.rd_last), 32'((k % 4) == 3));
      check("str_pass_last", 32'(bus_a.rd_pass_last), 32'(k >= 4));
      tick();
    end
    check("str_end_vld", 32'(bus_a.rd_vld), 32'd0);
    check("str_done", 32'(done_a), 32'd1);
    bus_a.rd_rdy = 1'b0;

    // S_DONE ignores writes until start
    bus_a.ctrl_vld = 1'b1;
    bus_a.wr_vector = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      check("done_no_rdy", 32'(bus_a.sram_rdy), 32'd0);
      check("done_hold", 32'(done_a), 32'd1);
      check("done_no_vld", 32'(bus_a.rd_vld), 32'd0);
      tick();
    end
    bus_a.ctrl_vld = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("rearm_done", 32'(done_a), 32'd0);
    check("rearm_rdy", 32'(bus_a.sram_rdy), 32'd1);

    // Backpressure: rd_rdy 1,0,0,1 repeating
    fill_a(8'hC0);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      bus_a.rd_rdy = bp_pat[cyc % 4];
      if (bus_a.rd_vld) begin
        check("bp_vec", 32'(bus_a.rd_vector), 32'(8'hC0 + 8'(idx % 4)));
        check("bp_last", 32'(bus_a.rd_last), 32'((idx % 4) == 3));
        check("bp_pass_last", 32'(bus_a.rd_pass_last), 32'(idx >= 4));
      end
      if (bus_a.rd_vld && bus_a.rd_rdy) idx++;
      tick();
      cyc++;
    end
    check("bp_count", idx, 32'd8);
    check("bp_done", 32'(done_a), 32'd1);
    bus_a.rd_rdy = 1'b0;

    // Reset mid-stream after three reads, then refill
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    fill_a(8'h50);
    bus_a.rd_rdy = 1'b1;
    tick();
    tick();
    tick();
    check("mid_vec", 32'(bus_a.rd_vector), 32'h53);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus_a.rd_vld), 32'd0);
    check("mid_rst_rdy", 32'(bus_a.sram_rdy), 32'd1);
    check("mid_rst_done", 32'(done_a), 32'd0);
    bus_a.rd_rdy = 1'b0;
    fill_a(8'hB0);
    bus_a.rd_rdy = 1'b1;
    tick();
    check("refill_second", 32'(bus_a.rd_vector), 32'hB1);
    bus_a.rd_rdy = 1'b0;

    // DEPTH=1, NUM_PASSES=1
    bus_b.ctrl_vld = 1'b1;
    bus_b.wr_vector = 8'h5A;
    check("d1_rdy", 32'(bus_b.sram_rdy), 32'd1);
    tick();
    bus_b.ctrl_vld = 1'b0;
    check("d1_closed", 32'(bus_b.sram_rdy), 32'd0);
    check("d1_lat1_vld", 32'(bus_b.rd_vld), 32'd0);
    tick();
    check("d1_vld", 32'(bus_b.rd_vld), 32'd1);
    check("d1_vec", 32'(bus_b.rd_vector), 32'h5A);
    check("d1_last", 32'(bus_b.rd_last), 32'd1);
    check("d1_pass_last", 32'(bus_b.rd_pass_last), 32'd1);
    bus_b.rd_rdy = 1'b1;
    tick();
    bus_b.rd_rdy = 1'b0;
    check("d1_end_vld", 32'(bus_b.rd_vld), 32'd0);
    check("d1_done", 32'(done_b), 32'd1);

`ifdef KV_SRAM_PARITY_EN
    check("par_clean_a", 32'(parity_err_a), 32'd0);
    check("par_clean_b", 32'(parity_err_b), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kv_vector_sram.md
Name: kv_vector_sram

Overview:
- Downstream of the memory controller: accepts the K (or V) vectors the controller assembles over a valid/ready handshake and stores all sequence positions.
- Replays the full stored sequence to the attention datapath once per Q vector.
- One instance each for K and V. The controller's phase advance depends on this block's `sram_rdy` acceptance of the final vector.

Parameters:
- DEPTH, `MAX_SEQ_LEN: vectors stored; sequence length.
- NUM_PASSES, `MAX_SEQ_LEN: full replays before done; one per Q vector.
- VEC_BITS, $bits(K_VECTOR_T): width of one stored vector.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ctrl_vld  in  1  controller offers wr_vector.
- wr_vector  in  VEC_BITS  vector from the controller (loaded_K_vector / loaded_V_vector).
- sram_rdy  out  1  block accepts a write this cycle.
- rd_vld  out  1  rd_vector valid to the datapath.
- rd_rdy  in  1  datapath accepts rd_vector.
- rd_vector  out  VEC_BITS  replayed vector.
- rd_last  out  1  rd_vector is entry DEPTH-1 of the current pass.
- rd_pass_last  out  1  current pass is pass NUM_PASSES-1.
- start  in  1  in S_DONE, rearm for a new load.
- done  out  1  all passes delivered.

Behaviour:
- Clocking and reset: single clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state=S_FILL, wr_ptr=0, rd_ptr=0, pass_cnt=0, rd_vld=0, rd_last=0, rd_pass_last=0, rd_vector=0, done=0. sram_rdy is 0 during the reset cycle and 1 from the first cycle after.
- Array contents are not cleared by reset. Reset mid-fill or mid-stream discards progress and restarts in S_FILL.
- States:
  - S_FILL: sram_rdy = 1 (combinational from state). A write fires when ctrl_vld && sram_rdy: store wr_vector at wr_ptr, wr_ptr++. The write that fires at wr_ptr == DEPTH-1 sets wr_ptr = 0 and moves to S_STREAM, so sram_rdy is 0 on the next cycle. No write is ever accepted outside S_FILL.
  - S_STREAM: registered-output read. The output register loads entry rd_ptr when (!rd_vld || rd_rdy) and entries remain.
    - Sustains one vector per cycle under continuous rd_rdy.
    - First rd_vld is asserted the cycle after entering S_STREAM, i.e. 2 cycles after the final write handshake.
    - rd_vector, rd_last and rd_pass_last hold stable while rd_vld && !rd_rdy.
    - rd_ptr wraps DEPTH-1 -> 0 and pass_cnt++ when loading entry DEPTH-1.
    - A handshake on a vector with rd_last && rd_pass_last moves to S_DONE. rd_vld drops the same edge unless another vector is loaded; none remains.
  - S_DONE: done=1, rd_vld=0, sram_rdy=0. start=1 moves to S_FILL and clears wr_ptr, rd_ptr and pass_cnt. start is ignored in any other state.
- Simultaneous events:
  - ctrl_vld while in S_STREAM or S_DONE: not accepted; the controller holds.
  - Load and handshake in the same cycle: a bubble-free replacement of the output register.
- Widths:
  - wr_ptr and rd_ptr: $clog2(DEPTH) bits.
  - pass_cnt: $clog2(NUM_PASSES)+1 bits.
  - Compare against constants; do not rely on natural overflow.
  - DEPTH=1 is legal: every vector carries rd_last=1.

Optional Feature:
- Macro: KV_SRAM_PARITY_EN.
- Enabled:
  - Each entry stores an extra even-parity bit over wr_vector.
  - Parity is checked when loading the output register.
  - A mismatch sets a sticky output parity_err (1 bit, reset 0, cleared only by rst or start).
  - Data is delivered unchanged.
- Disabled: no parity storage and no parity_err port.

Decomposition:
- The shared sys_defs package already provides K_VECTOR_T, V_VECTOR_T and `MAX_SEQ_LEN.
- Add to it the kv_sram_state_e enum (S_FILL, S_STREAM, S_DONE).
- One natural sub-module: vec_sram_array, a DEPTH x VEC_BITS, 1-write/1-read, flop-based array with synchronous write and combinational read address into the output register. It is swappable for an SRAM macro later.

Test Plan (DEPTH=4, NUM_PASSES=2 unless noted):
- Fill: write 4 vectors 0xA0..0xA3 with ctrl_vld held high -> sram_rdy high for exactly 4 accepted cycles, then 0. rd_vld first high 2 cycles after the 4th handshake.
- Stream: rd_rdy=1 constantly -> rd_vector sequence A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles. rd_last on A3 both times; rd_pass_last on the second pass only. done=1 the cycle after the final handshake.
- Backpressure: rd_rdy toggling 1,0,0,1 -> rd_vector held stable during stalls; no entry skipped or duplicated; total 8 handshakes.
- Reset mid-stream: rst pulsed after 3 reads -> next cycle rd_vld=0, sram_rdy=1. Refill with B0..B3 -> replay starts at B0.
- Rearm: in S_DONE drive ctrl_vld=1 without start -> not accepted. Pulse start -> S_FILL, new fill accepted. DEPTH=1, NUM_PASSES=1: one write, one read with rd_last=rd_pass_last=1.
- KV_SRAM_PARITY_EN: force-flip one stored bit of entry 2 -> parity_err rises when entry 2 is loaded and stays high until start.
